// File: rtl/rgb_pattern_pkg.sv
// Shared mode encoding for the RGB pattern generator.
package rgb_pattern_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_OFF     = 3'd0;
  localparam logic [MODE_W-1:0] MODE_BLINK   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_ALT     = 3'd2;
  localparam logic [MODE_W-1:0] MODE_CHASE   = 3'd3;
  localparam logic [MODE_W-1:0] MODE_BREATHE = 3'd4;

endpackage

// File: rtl/tick_prescaler.sv
// Pattern tick prescaler: counts 0..TICK_DIV-1 and pulses tick in the last count.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 12500000
) (
  input  logic clki,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == CNT_MAX);

endmodule

// File: rtl/rgb_pattern_gen.sv
// PWM-dimmed LED pattern generator (OFF/BLINK/ALT/CHASE); mode BREATHE is built
// only when RGB_PATTERN_BREATHE_EN is defined, otherwise it behaves as OFF.
module rgb_pattern_gen
  import rgb_pattern_pkg::*;
#(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned TICK_DIV = 12500000,
  parameter int unsigned PWM_W    = 8
) (
  input  logic              clki,
  input  logic              rst_n,
  input  logic              cfg_we_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [PWM_W-1:0]  duty_i,
  output logic [NUM_CH-1:0] rgb_o,
  output logic              tick_o
);

  localparam int unsigned STEP_W = $clog2(NUM_CH);

  logic              w_tick;
  logic              w_commit;
  logic              w_mode_change;
  logic [MODE_W-1:0] w_new_mode;
  logic [PWM_W-1:0]  w_new_duty;
  logic [PWM_W-1:0]  w_eff_duty;
  logic [NUM_CH-1:0] w_enable;
  logic              w_pwm_on;

  logic [PWM_W-1:0]  r_pwm;
  logic [STEP_W-1:0] r_step;
  logic              r_toggle;
  logic              r_pending;
  logic [MODE_W-1:0] r_shadow_mode;
  logic [PWM_W-1:0]  r_shadow_duty;
  logic [MODE_W-1:0] r_mode;
  logic [PWM_W-1:0]  r_duty;
  logic [NUM_CH-1:0] r_rgb;
  logic              r_tick;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_prescaler (
    .clki (clki),
    .rst_n(rst_n),
    .tick (w_tick)
  );

  // A write landing on the tick cycle bypasses the shadow and commits directly.
  assign w_commit      = w_tick & (cfg_we_i | r_pending);
  assign w_new_mode    = cfg_we_i ? mode_i : r_shadow_mode;
  assign w_new_duty    = cfg_we_i ? duty_i : r_shadow_duty;
  assign w_mode_change = w_commit & (w_new_mode != r_mode);

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      r_pending     <= 1'b0;
      r_shadow_mode <= MODE_OFF;
      r_shadow_duty <= '0;
      r_mode        <= MODE_OFF;
      r_duty        <= '0;
    end else if (w_tick) begin
      r_pending <= 1'b0;
      if (w_commit) begin
        r_mode <= w_new_mode;
        r_duty <= w_new_duty;
      end
    end else if (cfg_we_i) begin
      r_shadow_mode <= mode_i;
      r_shadow_duty <= duty_i;
      r_pending     <= 1'b1;
    end
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm    <= '0;
      r_step   <= '0;
      r_toggle <= 1'b0;
    end else begin
      r_pwm <= r_pwm + 1'b1;
      if (w_mode_change) begin
        r_step   <= '0;
        r_toggle <= 1'b0;
      end else if (w_tick) begin
        r_step   <= (r_step == STEP_W'(NUM_CH - 1)) ? '0 : r_step + 1'b1;
        r_toggle <= ~r_toggle;
      end
    end
  end

`ifdef RGB_PATTERN_BREATHE_EN
  logic r_ramp_down;
  logic [PWM_W-1:0] r_ramp;

  // Triangle ramp 0..duty..0, one step per PWM period so each window is uniform.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      r_ramp      <= '0;
      r_ramp_down <= 1'b0;
    end else if (w_commit) begin
      r_ramp      <= '0;
      r_ramp_down <= 1'b0;
    end else if (r_pwm == '1) begin
      if (!r_ramp_down) begin
        if (r_ramp < r_duty) begin
          r_ramp <= r_ramp + 1'b1;
        end else begin
          r_ramp_down <= 1'b1;
          if (r_ramp != '0) r_ramp <= r_ramp - 1'b1;
        end
      end else if (r_ramp != '0) begin
        r_ramp <= r_ramp - 1'b1;
      end else begin
        r_ramp_down <= 1'b0;
        if (r_duty != '0) r_ramp <= r_ramp + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    w_enable   = '0;
    w_eff_duty = '0;
    case (r_mode)
      MODE_BLINK: begin
        w_enable   = {NUM_CH{r_toggle}};
        w_eff_duty = r_duty;
      end
      MODE_ALT: begin
        for (int i = 0; i < NUM_CH; i++) w_enable[i] = r_toggle ^ ((i % 2) == 1);
        w_eff_duty = r_duty;
      end
      MODE_CHASE: begin
        for (int i = 0; i < NUM_CH; i++) w_enable[i] = (r_step == STEP_W'(i));
        w_eff_duty = r_duty;
      end
`ifdef RGB_PATTERN_BREATHE_EN
      MODE_BREATHE: begin
        w_enable   = '1;
        w_eff_duty = r_ramp;
      end
`endif
      default: begin
        w_enable   = '0;
        w_eff_duty = '0;
      end
    endcase
  end

  assign w_pwm_on = (r_pwm < w_eff_duty);

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_rgb  <= w_enable & {NUM_CH{w_pwm_on}};
      r_tick <= w_tick;
    end
  end

  assign rgb_o  = r_rgb;
  assign tick_o = r_tick;

endmodule
